// File: rtl/seq_divider_param_if.sv
// rtl/seq_divider_param_if.sv - request/response bundle for seq_divider_param
//
// Signals:
//   start  request strobe, sampled only while the divider is idle
//   sgn    1 = signed two's-complement division, 0 = unsigned
//   a      dividend
//   b      divisor
//   busy   operation in progress
//   done   one-cycle pulse; q, r and div0 are valid from this cycle
//   q      quotient, held until the next accepted start
//   r      remainder, held until the next accepted start
//   div0   divide-by-zero flag for the last result
// Modports: master drives the request, slave is the divider.

interface seq_divider_param_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div0;

  modport master (
    output start, sgn, a, b,
    input  busy, done, q, r, div0
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, q, r, div0
  );
endinterface

// File: rtl/seq_divider_param.sv
// rtl/seq_divider_param.sv - restoring shift-subtract divider, one quotient bit per clock
//
// Ports:
//   clk    clock, rising edge
//   Reset  synchronous, active-high reset
//   bus    seq_divider_param_if.slave (start/sgn/a/b in, busy/done/q/r/div0 out)
// Parameters:
//   WIDTH  operand/result width (4..64)
//   CNT_W  iteration counter width, derived
// Optional build macro:
//   DIVIDER_EARLY_EXIT_EN  finish on the start edge when |a| < |b| (results unchanged)

module seq_divider_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 Reset,
  seq_divider_param_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude; quotient bits shift in from the LSB
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] prem;     // partial remainder (always < dvs, so the top bit is implicit)
  logic             q_neg;
  logic             r_neg;
  logic             done_r;
  logic             div0_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    mag_a   = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b   = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    shifted = {prem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.b == '0) begin
              q_r    <= '1;
              r_r    <= bus.a;
              div0_r <= 1'b1;
              done_r <= 1'b1;
`ifdef DIVIDER_EARLY_EXIT_EN
            end else if (mag_a < mag_b) begin
              // Covers a==0 too: r = a = 0. Raw a already carries the dividend sign.
              q_r    <= '0;
              r_r    <= bus.a;
              div0_r <= 1'b0;
              done_r <= 1'b1;
`endif
            end else begin
              dvd   <= mag_a;
              dvs   <= mag_b;
              prem  <= '0;
              q_neg <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              r_neg <= bus.sgn & bus.a[WIDTH-1];
              cnt   <= CNT_W'(WIDTH);
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (!diff[WIDTH]) begin
            prem <= diff[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end

        FIX: begin
          // most-negative / -1 wraps naturally: magnitude 2^(W-1), positive sign.
          q_r    <= q_neg ? (~dvd + WIDTH'(1)) : dvd;
          r_r    <= r_neg ? (~prem + WIDTH'(1)) : prem;
          div0_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.q    = q_r;
  assign bus.r    = r_r;
  assign bus.div0 = div0_r;

endmodule
